pipeline_stall_ctrl: RTL and testbench

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

---
 rtl/pipeline_stall_ctrl.sv | 107 ++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall controller: load-use bubbles, branch flushes and a
// RUN/MISS/DONE data-cache refill sequence, plus a saturating stall-cycle counter.
module pipeline_stall_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hazard_i,
    input  logic             branch_taken_i,
    input  logic             dmem_req_i,
    input  logic             dmem_hit_i,
    input  logic             mem_ack_i,
    output logic             mem_req_o,
    output logic             PCWrite_o,
    output logic             IFID_Write_o,
    output logic             IFID_Flush_o,
    output logic             IDEX_Bubble_o,
    output logic             Pipe_Stall_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MISS = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state and pipeline control decode; reset forces every control low.
    always_comb begin
        state_d       = state_q;
        mem_req_o     = 1'b0;
        PCWrite_o     = 1'b0;
        IFID_Write_o  = 1'b0;
        IFID_Flush_o  = 1'b0;
        IDEX_Bubble_o = 1'b0;
        Pipe_Stall_o  = 1'b0;
        busy_o        = 1'b0;
        if (!rst_i) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (dmem_req_i && !dmem_hit_i) begin
                        Pipe_Stall_o = 1'b1;
                        state_d      = ST_MISS;
                    end else if (hazard_i) begin
                        // a taken branch is dropped here; it re-resolves next cycle
                        IDEX_Bubble_o = 1'b1;
                    end else begin
                        PCWrite_o    = 1'b1;
                        IFID_Write_o = 1'b1;
                        IFID_Flush_o = branch_taken_i;
                    end
                end
                ST_MISS: begin
                    mem_req_o    = 1'b1;
                    Pipe_Stall_o = 1'b1;
                    busy_o       = 1'b1;
                    if (mem_ack_i) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_MISS;
                    end
                end
                ST_DONE: begin
                    Pipe_Stall_o = 1'b1;
                    busy_o       = 1'b1;
                    state_d      = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Saturating count of cycles lost to stalls or bubbles.
    always_comb begin
        cnt_d = cnt_q;
        if ((Pipe_Stall_o || IDEX_Bubble_o) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Table-driven directed bench for pipeline_stall_ctrl, plus a counter
// saturation sequence on a narrow-counter instance.
module tb_pipeline_stall_ctrl;

    logic clk = 1'b0;
    logic rst_n, haz, br, dreq, dhit, ack;

    logic        mem_req, pcw, ifw, flush, bubble, stall, busy;
    logic [15:0] cnt;
    logic        s_mem_req, s_pcw, s_ifw, s_flush, s_bubble, s_stall, s_busy;
    logic [3:0]  s_cnt;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst_n), .hazard_i(haz), .branch_taken_i(br),
        .dmem_req_i(dreq), .dmem_hit_i(dhit), .mem_ack_i(ack),
        .mem_req_o(mem_req), .PCWrite_o(pcw), .IFID_Write_o(ifw),
        .IFID_Flush_o(flush), .IDEX_Bubble_o(bubble), .Pipe_Stall_o(stall),
        .busy_o(busy), .stall_cnt_o(cnt)
    );

    pipeline_stall_ctrl #(.CNT_W(4)) dut_small (
        .clk_i(clk), .rst_i(rst_n), .hazard_i(haz), .branch_taken_i(br),
        .dmem_req_i(dreq), .dmem_hit_i(dhit), .mem_ack_i(ack),
        .mem_req_o(s_mem_req), .PCWrite_o(s_pcw), .IFID_Write_o(s_ifw),
        .IFID_Flush_o(s_flush), .IDEX_Bubble_o(s_bubble), .Pipe_Stall_o(s_stall),
        .busy_o(s_busy), .stall_cnt_o(s_cnt)
    );

    // exp bit order: {mem_req, PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Stall, busy}
    typedef struct {
        logic [5:0]  in;   // {rst_n, haz, br, dreq, dhit, ack}
        logic [6:0]  exp;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    localparam logic [6:0] O_ZERO = 7'b000_0000;
    localparam logic [6:0] O_NORM = 7'b011_0000;
    localparam logic [6:0] O_BR   = 7'b011_1000;
    localparam logic [6:0] O_BUB  = 7'b000_0100;
    localparam logic [6:0] O_HIT  = 7'b000_0010;
    localparam logic [6:0] O_MISS = 7'b100_0011;
    localparam logic [6:0] O_DONE = 7'b000_0011;

    task automatic add(input logic [5:0] in, input logic [6:0] exp, input logic [15:0] c);
        vec_t v;
        v.in = in; v.exp = exp; v.cnt = c;
        vecs.push_back(v);
    endtask

    initial begin
        logic [6:0] got;
        logic [3:0] s_exp;
        // rst_n haz br dreq dhit ack
        add(6'b0_1_1_1_0_1, O_ZERO, 16'd0);   // reset forces all controls low
        add(6'b1_0_0_0_0_0, O_NORM, 16'd0);   // idle run
        add(6'b1_1_1_0_0_0, O_BUB,  16'd0);   // hazard beats branch
        add(6'b1_0_0_0_0_0, O_NORM, 16'd1);
        add(6'b1_0_1_0_0_0, O_BR,   16'd1);   // taken branch flush
        add(6'b1_0_0_1_1_0, O_NORM, 16'd1);   // cache hit, no stall
        add(6'b1_1_1_1_0_0, O_HIT,  16'd1);   // miss detected, beats hazard
        add(6'b1_1_0_0_0_0, O_MISS, 16'd2);   // MISS 1
        add(6'b1_0_0_0_0_0, O_MISS, 16'd3);   // MISS 2
        add(6'b1_0_0_0_0_0, O_MISS, 16'd4);   // MISS 3
        add(6'b1_0_0_0_0_1, O_MISS, 16'd5);   // MISS 4, ack
        add(6'b1_0_0_0_0_1, O_DONE, 16'd6);   // DONE ignores ack
        add(6'b1_0_0_0_0_1, O_NORM, 16'd7);   // RUN ignores ack
        add(6'b1_0_0_1_0_0, O_HIT,  16'd7);   // fast miss
        add(6'b1_0_0_0_0_1, O_MISS, 16'd8);   // ack in first MISS cycle
        add(6'b1_0_0_0_0_0, O_DONE, 16'd9);
        add(6'b1_0_0_0_0_0, O_NORM, 16'd10);  // back in RUN on cycle 4
        add(6'b1_0_0_1_0_0, O_HIT,  16'd10);  // miss to be abandoned
        add(6'b1_0_0_0_0_0, O_MISS, 16'd11);
        add(6'b0_0_0_0_0_0, O_ZERO, 16'd12);  // reset in second MISS cycle
        add(6'b1_0_0_0_0_1, O_NORM, 16'd0);   // late ack ignored
        add(6'b1_0_0_0_0_1, O_NORM, 16'd0);
        add(6'b1_1_0_0_0_0, O_BUB,  16'd0);

        {rst_n, haz, br, dreq, dhit, ack} = 6'b0_0_0_0_0_0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            {rst_n, haz, br, dreq, dhit, ack} = vecs[i].in;
            #1;
            got = {mem_req, pcw, ifw, flush, bubble, stall, busy};
            n_vec++;
            if (got !== vecs[i].exp || cnt !== vecs[i].cnt) begin
                n_bad++;
                $display("FAIL vec%0d: outs=%b cnt=%0d, required outs=%b cnt=%0d",
                         i, got, cnt, vecs[i].exp, vecs[i].cnt);
            end
        end

        // Saturation: 20 hazard cycles on the 4-bit counter instance.
        @(negedge clk);
        {rst_n, haz, br, dreq, dhit, ack} = 6'b0_0_0_0_0_0;
        @(negedge clk);
        {rst_n, haz, br, dreq, dhit, ack} = 6'b1_1_0_0_0_0;
        for (int i = 0; i <= 20; i++) begin
            #1;
            s_exp = (i > 15) ? 4'd15 : 4'(i);
            n_vec++;
            if (s_cnt !== s_exp || cnt !== 16'(i) || s_bubble !== 1'b1) begin
                n_bad++;
                $display("FAIL sat%0d: small_cnt=%0d cnt=%0d bubble=%b, required %0d %0d 1",
                         i, s_cnt, cnt, s_bubble, s_exp, i);
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
